multdiv_iter: RTL and testbench
===============================

MULTDIV_ITER -- requirements
Module: multdiv_iter

Interface
REQ-001 The block SHALL run on one clock and use a synchronous, active-high reset; ports are named clock and reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ctrl_MULT  input  1  start a signed multiply when sampled high in IDLE or DONE.
REQ-005 ctrl_DIV  input  1  start a signed divide when sampled high in IDLE or DONE.
REQ-006 data_operandA  input  32  multiplicand or dividend, two's complement.
REQ-007 data_operandB  input  32  multiplier or divisor, two's complement.
REQ-008 data_result  output  32  product low word or quotient.
REQ-009 data_exception  output  1  overflow or divide-error flag; valid while data_resultRDY is high.
REQ-010 data_resultRDY  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high while an operation is in RUN.

Function
REQ-012 The controller SHALL be a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE or DONE, start sampled at edge N:
  - operands and opcode latched at edge N;
  - iteration counter cleared to 0;
  - state goes to RUN.
REQ-014 ctrl_MULT and ctrl_DIV both high at a start edge: a multiply SHALL be performed.
REQ-015 ctrl_MULT or ctrl_DIV sampled during RUN SHALL be ignored, with no effect on state, operands or counter.
REQ-016 Iteration count and DONE timing:
  - RUN performs exactly 32 iterations, one per edge, at edges N+1..N+32;
  - counter increments 0..31 and does not wrap;
  - at edge N+32 the state goes to DONE.
REQ-017 data_resultRDY SHALL be high exactly during the period between edges N+32 and N+33, and low otherwise.
REQ-018 DONE with no start SHALL return to IDLE at the next edge; DONE with a start SHALL go to RUN per REQ-013.
REQ-019 data_result and data_exception SHALL update only at the DONE-entry edge and SHALL hold until the next DONE-entry edge or reset.
REQ-020 Multiply SHALL use radix-2 Booth recoding:
  - 65-bit accumulator {hi[32:0], lo[31:0]} plus one Booth bit;
  - one add, subtract or no-op of the sign-extended multiplicand per iteration, then an arithmetic shift right by 1.
REQ-021 Multiply result and exception:
  - data_result = product[31:0];
  - data_exception = 1 iff product[63:31] is not all-equal (does not fit in signed 32 bits).
REQ-022 Divide SHALL be restoring division on operand magnitudes, one quotient bit per iteration; the quotient is negated when the operand signs differ.
REQ-023 Divide rounding SHALL truncate toward zero; the remainder is not output.
REQ-024 Divisor 0: data_result = 0x00000000 and data_exception = 1, with the full 32-iteration latency kept.
REQ-025 Dividend 0x80000000 with divisor 0xFFFFFFFF: data_result = 0x80000000 and data_exception = 1.
REQ-026 Adder usage:
  - every 32-bit add/subtract in the datapath SHALL use the team's 32-bit carry-lookahead adder (eight 4-bit CLA slices, cin = 1 for subtract);
  - one adder instance is shared between multiply and divide.
REQ-027 The path from the adder to a register SHALL be the only combinational path per iteration; no output depends combinationally on the inputs.

Reset
REQ-028 reset high at an edge SHALL force, regardless of state and regardless of ctrl inputs sampled at that edge:
  - state IDLE;
  - counter 0;
  - data_result 0x00000000;
  - data_exception 0;
  - data_resultRDY 0;
  - busy 0.
REQ-029 Reset during RUN SHALL abort the operation; no data_resultRDY pulse follows for the aborted operation.

Verification
REQ-030 MULT with A=7, B=0xFFFFFFFD (-3) at edge N -> at edge N+32: result 0xFFFFFFEB, exception 0, RDY high for one cycle.
REQ-031 MULT with A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1; MULT with A=0x80000000, B=1 -> result 0x80000000, exception 0.
REQ-032 DIV with A=0xFFFFFFF9 (-7), B=2 -> result 0xFFFFFFFD, exception 0; DIV with A=5, B=0 -> result 0, exception 1; DIV with A=0x80000000, B=0xFFFFFFFF -> result 0x80000000, exception 1.
REQ-033 MULT 6×7 started, reset asserted at counter=10 -> no RDY pulse; MULT 6×7 restarted -> result 0x0000002A after 32 cycles.
REQ-034 Start and RUN-overlap rules:
  - ctrl_DIV pulsed during RUN of MULT 3×4 -> ignored, result 12 at the original edge N+32;
  - ctrl_MULT and ctrl_DIV together with A=9, B=3 -> result 27.
REQ-035 Back-to-back: MULT 2×3 started in DONE of the previous operation -> RDY pulse for the previous operation, then result 6 exactly 32 edges after the restart edge.

Source files
------------

// File: rtl/multdiv_iter.sv
// rtl/multdiv_iter.sv - iterative signed multiply (radix-2 Booth) / divide (restoring) on a shared CLA
// Helper adder slices live alongside the controller so the block stays self-contained.

module multdiv_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       pg,
  output logic       gg
);
  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;
  logic       c3;

  assign g   = a & b;
  assign p   = a ^ b;
  assign c1  = g[0] | (p[0] & cin);
  assign c2  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign sum = p ^ {c3, c2, c1, cin};
  assign pg  = &p;
  assign gg  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

module multdiv_cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [7:0] pg;
  logic [7:0] gg;
  logic [8:0] c;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = gg[i] | (pg[i] & c[i]);
    end
  end

  for (genvar s = 0; s < 8; s++) begin : g_slice
    multdiv_cla4 u_slice (
      .a   (a[4*s+3:4*s]),
      .b   (b[4*s+3:4*s]),
      .cin (c[s]),
      .sum (sum[4*s+3:4*s]),
      .pg  (pg[s]),
      .gg  (gg[s])
    );
  end

  assign cout = c[8];
endmodule

module multdiv_iter (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        op_div;
  logic [32:0] hi;
  logic [31:0] lo;
  logic        bbit;
  logic [31:0] opm;
  logic        sdiff;
  logic        bzero;
  logic [31:0] np;
  logic [31:0] nq;

  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;

  logic        bsub;
  logic        badd;
  logic [32:0] m_acc;
  logic [32:0] m_hi;
  logic [31:0] m_lo;
  logic        m_ovf;
  logic [31:0] abs_a;
  logic        qbit;
  logic [32:0] d_hi;
  logic [31:0] d_lo;
  logic [31:0] d_np;
  logic [31:0] d_nq;
  logic [31:0] d_res;
  logic        d_exc;

  assign bsub = lo[0] & ~bbit;
  assign badd = ~lo[0] & bbit;

  // Outside RUN the adder is idle, so it negates operand A for the divide magnitude.
  always_comb begin
    add_a   = '0;
    add_b   = ~data_operandA;
    add_cin = 1'b1;
    if (state == S_RUN) begin
      if (op_div) begin
        add_a   = {hi[30:0], lo[31]};
        add_b   = opm[31] ? opm : ~opm;
        add_cin = ~opm[31];
      end else begin
        add_a   = hi[31:0];
        add_b   = bsub ? ~opm : opm;
        add_cin = bsub;
      end
    end
  end

  multdiv_cla32 u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign abs_a = data_operandA[31] ? add_sum : data_operandA;

  // Bit 32 of the Booth accumulator is the sign-extension sum bit, fed by the CLA carry-out.
  assign m_acc = (bsub | badd) ? {hi[32] ^ add_b[31] ^ add_cout, add_sum} : hi;
  assign m_hi  = {m_acc[32], m_acc[32:1]};
  assign m_lo  = {m_acc[0], lo[31:1]};
  assign m_ovf = ~((&{m_hi[31:0], m_lo[31]}) | ~(|{m_hi[31:0], m_lo[31]}));

  // A set carry means the trial subtraction of |divisor| did not borrow.
  assign qbit = add_cout;
  assign d_hi = {1'b0, qbit ? add_sum : {hi[30:0], lo[31]}};
  assign d_lo = {lo[30:0], qbit};

  // np tracks -q and nq tracks -q-1 as quotient bits arrive MSB first, so negation needs no adder.
  assign d_np = qbit ? {nq[30:0], 1'b1} : {np[30:0], 1'b0};
  assign d_nq = qbit ? {nq[30:0], 1'b0} : {nq[30:0], 1'b1};

  assign d_res = bzero ? 32'h0000_0000 : (sdiff ? d_np : d_lo);
  assign d_exc = bzero | (~sdiff & d_lo[31]);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      op_div         <= 1'b0;
      hi             <= '0;
      lo             <= '0;
      bbit           <= 1'b0;
      opm            <= '0;
      sdiff          <= 1'b0;
      bzero          <= 1'b0;
      np             <= '0;
      nq             <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          data_resultRDY <= 1'b0;
          if (ctrl_MULT || ctrl_DIV) begin
            state  <= S_RUN;
            busy   <= 1'b1;
            cnt    <= '0;
            op_div <= ~ctrl_MULT;
            hi     <= '0;
            bbit   <= 1'b0;
            np     <= '0;
            nq     <= '1;
            sdiff  <= data_operandA[31] ^ data_operandB[31];
            bzero  <= (data_operandB == 32'h0000_0000);
            if (ctrl_MULT) begin
              opm <= data_operandA;
              lo  <= data_operandB;
            end else begin
              opm <= data_operandB;
              lo  <= abs_a;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (op_div) begin
            hi <= d_hi;
            lo <= d_lo;
            np <= d_np;
            nq <= d_nq;
          end else begin
            hi   <= m_hi;
            lo   <= m_lo;
            bbit <= lo[0];
          end
          if (cnt == 5'd31) begin
            state          <= S_DONE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            data_result    <= op_div ? d_res : m_lo;
            data_exception <= op_div ? d_exc : m_ovf;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        default: begin
          state          <= S_IDLE;
          busy           <= 1'b0;
          data_resultRDY <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multdiv_iter.sv
// tb/tb_multdiv_iter.sv - self-checking bench for multdiv_iter against an arithmetic reference model

module tb_multdiv_iter;
  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int errors = 0;

  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  multdiv_iter dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // Returns {exception, result} from plain signed arithmetic.
  function automatic logic [32:0] model(input logic is_div, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint r;
    sa = $signed(a);
    sb = $signed(b);
    if (!is_div) begin
      r = sa * sb;
      return {(r > MAXI) || (r < MINI), r[31:0]};
    end
    if (sb == 0) return {1'b1, 32'h0000_0000};
    r = sa / sb;
    return {(r > MAXI) || (r < MINI), r[31:0]};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    step();
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (data_resultRDY !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    ctrl_MULT = 1'b1;
    ctrl_DIV  = 1'b1;
    data_operandA = 32'd5;
    data_operandB = 32'd6;
    repeat (3) step();
    checks++; if (data_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h expected 00000000", data_result); end
    checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL reset_exception got %b expected 0", data_exception); end
    checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b expected 0", data_resultRDY); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    reset     = 1'b0;
    step();
    checks++; if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin errors++; $display("FAIL idle_after_reset got busy=%b rdy=%b expected 0 0", busy, data_resultRDY); end
  endtask

  task automatic test_directed();
    logic [97:0] tbl [10];
    logic        d;
    logic [31:0] a;
    logic [31:0] b;
    logic        ee;
    logic [31:0] er;
    int          n;
    tbl[0] = {1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFEB};
    tbl[1] = {1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0000};
    tbl[2] = {1'b0, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h8000_0000};
    tbl[3] = {1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFD};
    tbl[4] = {1'b1, 32'h0000_0005, 32'h0000_0000, 1'b1, 32'h0000_0000};
    tbl[5] = {1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000};
    tbl[6] = {1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000};
    tbl[7] = {1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h8000_0000};
    tbl[8] = {1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFD};
    tbl[9] = {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001};
    for (int i = 0; i < 10; i++) begin
      {d, a, b, ee, er} = tbl[i];
      start_op(~d, d, a, b);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dir%0d_busy got %b expected 1", i, busy); end
      wait_rdy(n);
      checks++; if (n != 32) begin errors++; $display("FAIL dir%0d_latency got %0d expected 32", i, n); end
      checks++; if (data_result !== er) begin errors++; $display("FAIL dir%0d_result got %h expected %h", i, data_result, er); end
      checks++; if (data_exception !== ee) begin errors++; $display("FAIL dir%0d_exception got %b expected %b", i, data_exception, ee); end
      step();
      checks++; if (data_resultRDY !== 1'b0 || data_result !== er) begin errors++; $display("FAIL dir%0d_hold got rdy=%b res=%h expected 0 %h", i, data_resultRDY, data_result, er); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    logic        m;
    logic        d;
    logic [32:0] exp;
    int          n;
    int          sel;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      a = $urandom;
      b = $urandom;
      if (sel == 1) begin
        a = 32'($urandom_range(0, 40)) - 32'd20;
        b = 32'($urandom_range(0, 40)) - 32'd20;
      end else if (sel == 2) begin
        b = 32'($urandom_range(0, 6)) - 32'd3;
      end
      d = $urandom_range(0, 1);
      m = ~d | ($urandom_range(0, 7) == 0);
      exp = model(~m, a, b);
      start_op(m, d, a, b);
      wait_rdy(n);
      checks++; if (n != 32) begin errors++; $display("FAIL rnd%0d_latency got %0d expected 32", i, n); end
      checks++; if ({data_exception, data_result} !== exp) begin
        errors++;
        $display("FAIL rnd%0d_%s a=%h b=%h got exc=%b res=%h expected exc=%b res=%h", i, m ? "mul" : "div", a, b, data_exception, data_result, exp[32], exp[31:0]);
      end
      step();
    end
  endtask

  task automatic test_reset_abort();
    int n;
    int saw;
    start_op(1'b1, 1'b0, 32'd6, 32'd7);
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || data_result !== 32'h0) begin errors++; $display("FAIL abort_state got busy=%b res=%h expected 0 00000000", busy, data_result); end
    saw = 0;
    repeat (40) begin
      step();
      if (data_resultRDY === 1'b1) saw = 1;
    end
    checks++; if (saw != 0) begin errors++; $display("FAIL abort_no_rdy got pulse=%0d expected 0", saw); end
    start_op(1'b1, 1'b0, 32'd6, 32'd7);
    wait_rdy(n);
    checks++; if (n != 32 || data_result !== 32'h0000_002A) begin errors++; $display("FAIL abort_restart got n=%0d res=%h expected 32 0000002a", n, data_result); end
    step();
  endtask

  task automatic test_overlap();
    int n;
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    step();
    ctrl_DIV = 1'b0;
    repeat (4) step();
    wait_rdy(n);
    checks++; if (n + 5 != 32) begin errors++; $display("FAIL overlap_latency got %0d expected 32", n + 5); end
    checks++; if (data_result !== 32'd12 || data_exception !== 1'b0) begin errors++; $display("FAIL overlap_result got res=%h exc=%b expected 0000000c 0", data_result, data_exception); end
    step();
    start_op(1'b1, 1'b1, 32'd9, 32'd3);
    wait_rdy(n);
    checks++; if (n != 32 || data_result !== 32'd27) begin errors++; $display("FAIL both_ctrl got n=%0d res=%h expected 32 0000001b", n, data_result); end
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    start_op(1'b1, 1'b0, 32'd5, 32'd5);
    wait_rdy(n);
    checks++; if (n != 32 || data_result !== 32'd25) begin errors++; $display("FAIL b2b_first got n=%0d res=%h expected 32 00000019", n, data_result); end
    start_op(1'b1, 1'b0, 32'd2, 32'd3);
    checks++; if (data_resultRDY !== 1'b0 || busy !== 1'b1 || data_result !== 32'd25) begin
      errors++;
      $display("FAIL b2b_restart got rdy=%b busy=%b res=%h expected 0 1 00000019", data_resultRDY, busy, data_result);
    end
    wait_rdy(n);
    checks++; if (n != 32 || data_result !== 32'd6 || data_exception !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got n=%0d res=%h exc=%b expected 32 00000006 0", n, data_result, data_exception);
    end
    step();
    step();
    checks++; if (data_resultRDY !== 1'b0 || busy !== 1'b0 || data_result !== 32'd6) begin
      errors++;
      $display("FAIL b2b_idle got rdy=%b busy=%b res=%h expected 0 0 00000006", data_resultRDY, busy, data_result);
    end
  endtask

  initial begin
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    reset         = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_reset_abort();
    test_overlap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
